// File: rtl/puf_crp_if.sv
// CRP stream between the PUF sequencer and host logic: valid/ready handshake
// carrying the challenge, the majority-voted response and per-bit instability flags.
interface puf_crp_if #(
   parameter int C_LENGTH = 8,
   parameter int RESP_W   = 7
);
   logic                crp_valid;
   logic                crp_ready;
   logic [C_LENGTH-1:0] crp_challenge;
   logic [RESP_W-1:0]   crp_response;
   logic [RESP_W-1:0]   crp_unstable;

   modport master (
      output crp_valid, crp_challenge, crp_response, crp_unstable,
      input  crp_ready
   );

   modport slave (
      input  crp_valid, crp_challenge, crp_response, crp_unstable,
      output crp_ready
   );
endinterface

// File: rtl/puf_crp_sequencer.sv
// Arbiter-PUF initiator: steps challenges (LFSR or increment), launches repeated
// evaluations with settle/hold timing, majority-votes the responses and streams CRPs.
module puf_crp_sequencer #(
   parameter int C_LENGTH      = 8,
   parameter int RESP_W        = 7,
   parameter int SETTLE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 4,
   parameter int REPEATS       = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                mode,
   input  logic [C_LENGTH-1:0] seed,
   input  logic [7:0]          count,
   output logic [C_LENGTH-1:0] challenge,
   output logic                pulse,
   input  logic [RESP_W-1:0]   response,
   output logic                busy,
   output logic                done,
   puf_crp_if.master           crp
);

   typedef enum logic [2:0] {IDLE, ARM, FIRE, PRESENT, DONE} state_t;

   state_t              state, state_next;
   logic [7:0]          timer;
   logic [3:0]          rep_idx;
   logic [8:0]          remaining;
   logic                mode_inc;
   logic [RESP_W-1:0]   resp_meta, resp_sync;
   logic [3:0]          votes [RESP_W];
   logic                settle_end, hold_end, last_repeat, handshake;
   logic [C_LENGTH-1:0] chal_next;

   assign settle_end  = (timer == 8'(SETTLE_CYCLES - 1));
   assign hold_end    = (timer == 8'(HOLD_CYCLES - 1));
   assign last_repeat = (rep_idx == 4'(REPEATS - 1));
   assign chal_next   = mode_inc ? challenge + C_LENGTH'(1)
                                 : {challenge[C_LENGTH-2:0],
                                    challenge[7] ^ challenge[5] ^ challenge[4] ^ challenge[3]};

   // The arbiter outputs settle asynchronously to clk, so they are only used after two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_meta <= '0;
         resp_sync <= '0;
      end else begin
         resp_meta <= response;
         resp_sync <= resp_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next        = state;
      pulse             = 1'b0;
      busy              = 1'b1;
      done              = 1'b0;
      handshake         = 1'b0;
      crp.crp_valid     = 1'b0;
      crp.crp_challenge = '0;
      crp.crp_response  = '0;
      crp.crp_unstable  = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = ARM;
         end
         ARM: begin
            if (settle_end) state_next = FIRE;
         end
         FIRE: begin
            pulse = 1'b1;
            if (hold_end) state_next = last_repeat ? PRESENT : ARM;
         end
         PRESENT: begin
            crp.crp_valid     = 1'b1;
            crp.crp_challenge = challenge;
            for (int b = 0; b < RESP_W; b++) begin
               crp.crp_response[b] = (votes[b] > 4'(REPEATS / 2));
               crp.crp_unstable[b] = (votes[b] != 4'd0) && (votes[b] != 4'(REPEATS));
            end
            handshake = crp.crp_ready;
            if (handshake) state_next = (remaining == 9'd1) ? DONE : ARM;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Timer restarts on every phase change so ARM and FIRE each measure their own length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         challenge <= '0;
         timer     <= '0;
         rep_idx   <= '0;
         remaining <= '0;
         mode_inc  <= 1'b0;
         for (int b = 0; b < RESP_W; b++) votes[b] <= '0;
      end else begin
         if ((state_next != state) || !((state == ARM) || (state == FIRE)))
            timer <= '0;
         else
            timer <= timer + 8'd1;

         case (state)
            IDLE: begin
               if (start) begin
                  mode_inc  <= mode;
                  remaining <= (count == 8'd0) ? 9'd256 : {1'b0, count};
                  rep_idx   <= '0;
                  challenge <= (!mode && (seed == '0)) ? C_LENGTH'(1) : seed;
                  for (int b = 0; b < RESP_W; b++) votes[b] <= '0;
               end
            end
            FIRE: begin
               if (hold_end) begin
                  for (int b = 0; b < RESP_W; b++) votes[b] <= votes[b] + {3'b000, resp_sync[b]};
                  if (!last_repeat) rep_idx <= rep_idx + 4'd1;
               end
            end
            PRESENT: begin
               if (handshake && (remaining != 9'd1)) begin
                  remaining <= remaining - 9'd1;
                  challenge <= chal_next;
                  rep_idx   <= '0;
                  for (int b = 0; b < RESP_W; b++) votes[b] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
